// File: rtl/dm_responder.sv
// -----------------------------------------------------------------------------
// dm_responder
// Data-memory responder for the pipelined CPU's DM port. After reset the
// internal controller walks the array through three phases:
//    SCRUB : zero every word, one word per cycle (skipped when SCRUB_EN=0)
//    LOAD  : accept program/data words over a valid/ready loader port
//    RUN   : serve the CPU SRAM-style port (one-cycle registered read,
//            bit-masked write, write-first read-during-write)
// mem_ready keeps the CPU in reset until RUN is reached.
//
// Ports
//    clk        single clock, rising edge
//    rst        synchronous active-high reset
//    DM_WEB     active-low CPU write enable
//    DM_BWEB    per-bit active-low write mask (bit i written when 0)
//    DM_A       CPU word address
//    DM_IN      CPU write data
//    DM_OUT     registered CPU read data
//    ld_valid   loader word valid
//    ld_ready   loader can accept a word (decoded from state)
//    ld_addr    loader word address
//    ld_data    loader word data
//    ld_last    marks the final loader word
//    ld_count   words accepted since reset, saturating
//    mem_ready  high only in RUN (decoded from state)
// -----------------------------------------------------------------------------
module dm_responder #(
   parameter int ADDR_W   = 14,
   parameter int DATA_W   = 32,
   parameter int DEPTH    = 2**ADDR_W,
   parameter bit SCRUB_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              DM_WEB,
   input  logic [DATA_W-1:0] DM_BWEB,
   input  logic [ADDR_W-1:0] DM_A,
   input  logic [DATA_W-1:0] DM_IN,
   output logic [DATA_W-1:0] DM_OUT,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              ld_last,
   output logic [ADDR_W:0]   ld_count,
   output logic              mem_ready
);

   localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH-1);
   localparam logic [ADDR_W:0]   COUNT_MAX = '1;

   typedef enum logic [1:0] {
      ST_SCRUB,
      ST_LOAD,
      ST_RUN
   } state_t;

   localparam state_t START_STATE = SCRUB_EN ? ST_SCRUB : ST_LOAD;

   state_t            r_state;
   state_t            w_nextState;
   logic [ADDR_W-1:0] r_scrubCnt;
   logic [DATA_W-1:0] r_mem [DEPTH];

   logic              w_cpuInRange;
   logic              w_ldInRange;
   logic [DATA_W-1:0] w_memWord;
   logic [DATA_W-1:0] w_merged;
   logic              w_wrEn;
   logic [ADDR_W-1:0] w_wrAddr;
   logic [DATA_W-1:0] w_wrData;

   // Addresses beyond DEPTH read as zero and never write; the merged word is
   // what a CPU write would store and is also what a write-first read returns.
   assign w_cpuInRange = ({1'b0, DM_A} < DEPTH_W);
   assign w_ldInRange  = ({1'b0, ld_addr} < DEPTH_W);
   assign w_memWord    = w_cpuInRange ? r_mem[DM_A] : '0;
   assign w_merged     = (w_memWord & DM_BWEB) | (DM_IN & ~DM_BWEB);

   // State register; any reset restarts the whole scrub/load/run sequence.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= START_STATE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state decode plus the single memory write port mux. Only one phase
   // owns the array at a time, so one write port covers scrub, load and CPU.
   always_comb begin
      w_nextState = r_state;
      ld_ready    = 1'b0;
      mem_ready   = 1'b0;
      w_wrEn      = 1'b0;
      w_wrAddr    = DM_A;
      w_wrData    = w_merged;
      case (r_state)
         ST_SCRUB: begin
            w_wrEn   = 1'b1;
            w_wrAddr = r_scrubCnt;
            w_wrData = '0;
            if (r_scrubCnt == LAST_ADDR) begin
               w_nextState = ST_LOAD;
            end
         end
         ST_LOAD: begin
            ld_ready = 1'b1;
            if (ld_valid) begin
               w_wrEn   = w_ldInRange;
               w_wrAddr = ld_addr;
               w_wrData = ld_data;
               if (ld_last) begin
                  w_nextState = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            mem_ready = 1'b1;
            if (!DM_WEB) begin
               w_wrEn = w_cpuInRange;
            end
         end
         default: begin
            w_nextState = START_STATE;
         end
      endcase
   end

   // The array itself has no reset; writes are suppressed while rst is high
   // so that asserting reset never disturbs stored contents.
   always_ff @(posedge clk) begin
      if (w_wrEn && !rst) begin
         r_mem[w_wrAddr] <= w_wrData;
      end
   end

   // Scrub address walks 0..DEPTH-1 once per reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_scrubCnt <= '0;
      end else if (r_state == ST_SCRUB) begin
         r_scrubCnt <= r_scrubCnt + 1'b1;
      end
   end

   // Read data refreshes every RUN cycle; on a write cycle it returns the
   // freshly merged word so a following load sees the new value.
   always_ff @(posedge clk) begin
      if (rst) begin
         DM_OUT <= '0;
      end else if (r_state == ST_RUN) begin
         if (!w_cpuInRange) begin
            DM_OUT <= '0;
         end else if (!DM_WEB) begin
            DM_OUT <= w_merged;
         end else begin
            DM_OUT <= w_memWord;
         end
      end else begin
         DM_OUT <= '0;
      end
   end

   // Count accepted loader words, sticking at all-ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         ld_count <= '0;
      end else if ((r_state == ST_LOAD) && ld_valid && (ld_count != COUNT_MAX)) begin
         ld_count <= ld_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_dm_responder.sv
// -----------------------------------------------------------------------------
// tb_dm_responder
// Directed plus randomized bench for dm_responder with a 16-word array. A
// plain array holds the expected memory image; CPU operations update it with
// the masked-merge rule and DM_OUT is compared one cycle later.
// -----------------------------------------------------------------------------
module tb_dm_responder;

   localparam int AW = 4;
   localparam int DW = 32;
   localparam int NW = 16;

   logic          clk      = 1'b0;
   logic          rst      = 1'b1;
   logic          DM_WEB   = 1'b1;
   logic [DW-1:0] DM_BWEB  = '1;
   logic [AW-1:0] DM_A     = '0;
   logic [DW-1:0] DM_IN    = '0;
   logic          ld_valid = 1'b0;
   logic [AW-1:0] ld_addr  = '0;
   logic [DW-1:0] ld_data  = '0;
   logic          ld_last  = 1'b0;
   logic [DW-1:0] DM_OUT;
   logic          ld_ready;
   logic [AW:0]   ld_count;
   logic          mem_ready;

   int            checks = 0;
   int            errors = 0;
   logic [DW-1:0] model [NW];
   int            scrubCycles;
   logic [DW-1:0] rnd7;
   logic [DW-1:0] rnd8;

   dm_responder #(
      .ADDR_W  (AW),
      .DATA_W  (DW),
      .DEPTH   (NW),
      .SCRUB_EN(1'b1)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .DM_WEB   (DM_WEB),
      .DM_BWEB  (DM_BWEB),
      .DM_A     (DM_A),
      .DM_IN    (DM_IN),
      .DM_OUT   (DM_OUT),
      .ld_valid (ld_valid),
      .ld_ready (ld_ready),
      .ld_addr  (ld_addr),
      .ld_data  (ld_data),
      .ld_last  (ld_last),
      .ld_count (ld_count),
      .mem_ready(mem_ready)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // One rising edge, then settle so outputs are sampled away from the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic web, input logic [DW-1:0] bweb,
                                input logic [AW-1:0] a, input logic [DW-1:0] din);
      DM_WEB  = web;
      DM_BWEB = bweb;
      DM_A    = a;
      DM_IN   = din;
      tick();
   endtask

   // One CPU access: the expected image changes bit by bit where the mask is
   // low, and the read-back value is the resulting word.
   task automatic cpuOp(input string tag, input logic web, input logic [DW-1:0] bweb,
                        input logic [AW-1:0] a, input logic [DW-1:0] din);
      logic [DW-1:0] expWord;
      if (!web) begin
         for (int b = 0; b < DW; b++) begin
            if (!bweb[b]) model[a][b] = din[b];
         end
      end
      expWord = model[a];
      applyStimulus(web, bweb, a, din);
      checkOutput(tag, DM_OUT, expWord);
   endtask

   task automatic loadWord(input logic v, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic last);
      ld_valid = v;
      ld_addr  = a;
      ld_data  = d;
      ld_last  = last;
      tick();
   endtask

   task automatic doReset();
      rst = 1'b1;
      tick();
      rst      = 1'b0;
      ld_valid = 1'b0;
      checkOutput("rst_dm_out", DM_OUT, 0);
      checkOutput("rst_ld_count", ld_count, 0);
      checkOutput("rst_mem_ready", mem_ready, 0);
      checkOutput("rst_ld_ready", ld_ready, 0);
   endtask

   // Bounded wait for LOAD; an expired bound shows up as a wrong length.
   task automatic waitScrub(output int n);
      n = 0;
      while (ld_ready !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      checkOutput("scrub_len", n, NW);
      for (int i = 0; i < NW; i++) model[i] = '0;
   endtask

   task automatic readAll(input string tag);
      DM_WEB = 1'b1;
      for (int i = 0; i < NW; i++) begin
         cpuOp(tag, 1'b1, $urandom, AW'(i), $urandom);
      end
   endtask

   initial begin
      // Reset, scrub, then fill the whole array with ones through the loader.
      doReset();
      waitScrub(scrubCycles);
      checkOutput("load_dm_out_zero", DM_OUT, 0);
      for (int i = 0; i < NW; i++) begin
         loadWord(1'b1, AW'(i), 32'hFFFF_FFFF, i == NW-1);
         model[i] = 32'hFFFF_FFFF;
      end
      ld_valid = 1'b0;
      checkOutput("fill_mem_ready", mem_ready, 1);
      checkOutput("fill_ld_count", ld_count, NW);
      cpuOp("fill_read3", 1'b1, '0, 4'd3, '0);

      // Second reset: scrub must clear the ones; CPU writes during LOAD ignored.
      doReset();
      waitScrub(scrubCycles);
      DM_WEB  = 1'b0;
      DM_BWEB = '0;
      DM_IN   = 32'hFFFF_FFFF;
      DM_A    = 4'd4;
      loadWord(1'b1, 4'd0, 32'hA0, 1'b0);
      checkOutput("load_cnt1", ld_count, 1);
      checkOutput("load_dm_out_held", DM_OUT, 0);
      loadWord(1'b0, 4'd1, 32'hDEAD, 1'b1);
      checkOutput("load_idle_cnt", ld_count, 1);
      checkOutput("load_idle_ready", mem_ready, 0);
      loadWord(1'b1, 4'd1, 32'hA1, 1'b0);
      DM_WEB = 1'b1;
      loadWord(1'b1, 4'd2, 32'hA2, 1'b1);
      model[0] = 32'hA0;
      model[1] = 32'hA1;
      model[2] = 32'hA2;
      checkOutput("run_mem_ready", mem_ready, 1);
      checkOutput("run_ld_ready", ld_ready, 0);
      checkOutput("run_ld_count", ld_count, 3);
      loadWord(1'b1, 4'd3, 32'h55, 1'b1);
      ld_valid = 1'b0;
      checkOutput("run_ld_ignored", ld_count, 3);

      // Consecutive reads 0..15 trail DM_A by one cycle.
      readAll("read_after_load");

      // Masked write with write-first read-back.
      cpuOp("wr5_full", 1'b0, '0, 4'd5, 32'h1122_3344);
      cpuOp("wr5_mask", 1'b0, 32'hFFFF_00FF, 4'd5, 32'hAABB_CCDD);
      checkOutput("wr5_mask_const", DM_OUT, 32'h1122_CC44);
      cpuOp("rd5", 1'b1, '0, 4'd0, '0);
      cpuOp("rd5b", 1'b1, '0, 4'd5, '0);
      checkOutput("rd5_const", DM_OUT, 32'h1122_CC44);

      // Fully masked write and a disabled write leave the word alone.
      cpuOp("wr5_allmask", 1'b0, 32'hFFFF_FFFF, 4'd5, 32'hFFFF_FFFF);
      cpuOp("wr5_disabled", 1'b1, '0, 4'd5, 32'h0);
      cpuOp("rd5_after", 1'b1, '0, 4'd5, 32'h0);
      checkOutput("rd5_after_const", DM_OUT, 32'h1122_CC44);

      // Randomized CPU traffic against the expected image.
      for (int k = 0; k < 300; k++) begin
         cpuOp("rand_op", 1'($urandom_range(0, 1)), $urandom,
               AW'($urandom_range(0, NW-1)), $urandom);
      end
      readAll("read_after_rand");

      // Reset mid-LOAD restarts the sequence and the scrub wipes loaded words.
      doReset();
      waitScrub(scrubCycles);
      rnd7 = $urandom | 32'h1;
      rnd8 = $urandom | 32'h1;
      loadWord(1'b1, 4'd7, rnd7, 1'b0);
      loadWord(1'b1, 4'd8, rnd8, 1'b0);
      checkOutput("midload_cnt", ld_count, 2);
      doReset();
      waitScrub(scrubCycles);
      loadWord(1'b1, 4'd0, 32'h77, 1'b1);
      ld_valid = 1'b0;
      model[0] = 32'h77;
      checkOutput("reload_mem_ready", mem_ready, 1);
      checkOutput("reload_ld_count", ld_count, 1);
      readAll("read_after_reload");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
